// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 3-bit control encoding used by the main decoder
// and the arbiter, plus the arbiter's output-slot state type.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/alu_core.sv
// Purely combinational integer ALU: (ctrl, a, b) -> (result, zero).
// Shared by the single-cycle datapath and the ALU arbiter.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    alu_ctrl_t      op;
    logic [SHW-1:0] shamt;
    logic           lt_signed;

    always_comb begin
        op        = alu_ctrl_t'(ctrl_i);
        // Only the low SHW bits of b select the shift distance.
        shamt     = b_i[SHW-1:0];
        lt_signed = $signed(a_i) < $signed(b_i);
        result_o  = '0;
        case (op)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_SLL: result_o = a_i << shamt;
            ALU_SRL: result_o = a_i >> shamt;
            default: result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a one-entry
// registered result slot that can be drained and refilled in the same cycle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [5:0]           req_ctrl,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_id
);

    // Handshake: a transfer happens on valid & ready on either side. Requesters
    // hold valid/payload until accepted; ready never depends on the slot's
    // contents beyond FULL/EMPTY, and the rsp_* outputs are purely registered.

    slot_state_t      state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             id_q;
    logic             last_grant_q;

    logic             grant_idx;
    logic             accept;
    logic             xfer;
    logic [2:0]       sel_ctrl;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    always_comb begin
        // On a tie the requester that did not win last time goes next.
        grant_idx = (&req_valid) ? ~last_grant_q : req_valid[1];
        accept    = (state_q == SLOT_EMPTY) || rsp_ready;
        if (!reset && (|req_valid) && accept) begin
            req_ready = grant_idx ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
        xfer     = |(req_valid & req_ready);
        sel_ctrl = grant_idx ? req_ctrl[5:3]         : req_ctrl[2:0];
        sel_a    = grant_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        sel_b    = grant_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    end

    alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_alu_core (
        .ctrl_i   (sel_ctrl),
        .a_i      (sel_a),
        .b_i      (sel_b),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SLOT_EMPTY;
            result_q     <= '0;
            zero_q       <= 1'b1;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (xfer) begin
            state_q      <= SLOT_FULL;
            result_q     <= alu_result;
            zero_q       <= alu_zero;
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
        end else if ((state_q == SLOT_FULL) && rsp_ready) begin
            // Drained without refill; stale result/zero/id are left in place.
            state_q <= SLOT_EMPTY;
        end
    end

    assign rsp_valid  = (state_q == SLOT_FULL);
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_id     = id_q;

endmodule
